seq_det_ctrl: RTL and testbench

Run controller for the serial sequence-detection path. Holds a programmable PAT_W-bit pattern, match mode and match limit. Arms and disarms detection on command and runs a Mealy compare against the incoming bit stream. Counts matches and stops the run when the limit is hit. Sits between the register/command interface and the serial input, and replaces hard-wired per-pattern detectors.

---
 rtl/seq_det_pkg.sv | 24 ++
 rtl/seq_det_if.sv | 14 +
 rtl/seq_det_core.sv | 45 ++++
 rtl/seq_det_ctrl.sv | 131 +++++++++++++
 tb/tb_seq_det_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and reset constants for the serial sequence-detection run controller.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0]  DEF_PATTERN_W4 = 4'b1001;
    localparam int unsigned DEF_LIMIT      = 32'd0;

    // Reset pattern: 1001 for a 4-bit pattern, all zeros for any other width.
    function automatic logic [7:0] default_pattern(input int unsigned pat_w);
        logic [7:0] pat_v;
        if (pat_w == 32'd4) begin
            pat_v = {4'b0000, DEF_PATTERN_W4};
        end else begin
            pat_v = 8'h00;
        end
        return pat_v;
    endfunction

endpackage

// File: rtl/seq_det_if.sv
// Configuration offer/accept channel carrying pattern, overlap mode and match limit.
interface seq_det_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_limit;

    modport master (output cfg_valid, cfg_pattern, cfg_overlap, cfg_limit, input cfg_ready);
    modport slave  (input cfg_valid, cfg_pattern, cfg_overlap, cfg_limit, output cfg_ready);
endinterface

// File: rtl/seq_det_core.sv
// Bit history, fill counter and Mealy pattern compare for the sequence detector.
module seq_det_core #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);
    localparam int              FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  history_r;
    logic [FILL_W-1:0] fill_r;
    logic [PAT_W-1:0]  window_s;

    // The window is the oldest PAT_W-1 bits followed by the bit arriving now.
    assign window_s = {history_r, bit_in};
    assign match    = shift && (fill_r == FILL_MAX) && (window_s == pattern);

    // History and fill update; a non-overlapping match forces a full refill.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            history_r <= '0;
            fill_r    <= '0;
        end else if (shift) begin
            history_r <= window_s[PAT_W-2:0];
            if (match && !overlap) begin
                fill_r <= '0;
            end else if (fill_r != FILL_MAX) begin
                fill_r <= fill_r + FILL_W'(1);
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            history_r <= history_r;
            fill_r    <= fill_r;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller: config registers, IDLE/RUN/DONE FSM and match counter.
// Optional sticky limit interrupt on port irq is built when SEQ_DET_IRQ_EN is defined.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    seq_det_if.slave         cfg,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done
`ifdef SEQ_DET_IRQ_EN
    ,
    output logic             irq
`endif
);
    localparam logic [7:0]       DEF_PAT8 = default_pattern(unsigned'(PAT_W));
    localparam logic [PAT_W-1:0] DEF_PAT  = DEF_PAT8[PAT_W-1:0];
    localparam logic [CNT_W-1:0] DEF_LIM  = CNT_W'(DEF_LIMIT);

    state_e           state_r, state_next_s;
    logic [PAT_W-1:0] pattern_r;
    logic             overlap_r;
    logic [CNT_W-1:0] limit_r;
    logic [CNT_W-1:0] count_r, count_next_s, count_inc_s;
    logic             clear_s, shift_s, cfg_fire_s;

    assign cfg.cfg_ready = (state_r != RUN);
    assign cfg_fire_s    = cfg.cfg_valid && (state_r != RUN);
    assign shift_s       = (state_r == RUN) && bit_valid;
    assign count_inc_s   = (count_r == '1) ? count_r : (count_r + CNT_W'(1));
    assign match_count   = count_r;
    assign busy          = (state_r == RUN);
    assign done          = (state_r == DONE);

    seq_det_core #(.PAT_W(PAT_W)) u_core (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_s),
        .shift   (shift_s),
        .bit_in  (bit_in),
        .pattern (pattern_r),
        .overlap (overlap_r),
        .match   (match)
    );

    // Next state and counter; abort wins over a limiting match but the match still counts.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        clear_s      = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s = RUN;
                    count_next_s = '0;
                    clear_s      = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            RUN: begin
                if (match) begin
                    count_next_s = count_inc_s;
                end else begin
                    count_next_s = count_r;
                end
                if (abort) begin
                    state_next_s = IDLE;
                end else if (match && (limit_r != '0) && (count_inc_s == limit_r)) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, counter and configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            count_r   <= '0;
            pattern_r <= DEF_PAT;
            overlap_r <= 1'b1;
            limit_r   <= DEF_LIM;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            if (cfg_fire_s) begin
                pattern_r <= cfg.cfg_pattern;
                overlap_r <= cfg.cfg_overlap;
                limit_r   <= cfg.cfg_limit;
            end else begin
                pattern_r <= pattern_r;
                overlap_r <= overlap_r;
                limit_r   <= limit_r;
            end
        end
    end

`ifdef SEQ_DET_IRQ_EN
    logic irq_r;
    assign irq = irq_r;

    // Sticky limit interrupt: set entering DONE, cleared only by a new run or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else if (clear_s) begin
            irq_r <= 1'b0;
        end else if ((state_r == RUN) && (state_next_s == DONE)) begin
            irq_r <= 1'b1;
        end else begin
            irq_r <= irq_r;
        end
    end
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: match scoreboard plus per-scenario status checks.
module tb_seq_det_ctrl;
    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic match, busy, done;
    logic [CNT_W-1:0] match_count;
`ifdef SEQ_DET_IRQ_EN
    logic irq;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    seq_det_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) cfg_if ();

    seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg         (cfg_if),
        .start       (start),
        .abort       (abort),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
`ifdef SEQ_DET_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    // Scoreboard: every valid bit pops its expected match; no match without a valid bit.
    always @(negedge clk) begin
        logic e;
        if (bit_valid === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL match_scoreboard: match=%b but no expected entry queued", match);
            end else begin
                e = exp_q.pop_front();
                if (match !== e) $display("FAIL match_scoreboard: match=%b expected %b at %0t", match, e, $time);
                else pass_cnt++;
            end
        end else if (reset === 1'b0) begin
            total_cnt++;
            if (match !== 1'b0) $display("FAIL match_idle: match=%b expected 0 at %0t", match, $time);
            else pass_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic e);
        exp_q.push_back(e);
        bit_in = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        bit_in = 1'b0;
    endtask

    task automatic send_stream(input logic [15:0] bits, input logic [15:0] exps, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i], exps[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_pattern = 4'b0000;
        cfg_if.cfg_overlap = 1'b0;
        cfg_if.cfg_limit = 8'd0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (match_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", match_count); else pass_cnt++;
        total_cnt++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b want 1", cfg_if.cfg_ready); else pass_cnt++;
`ifdef SEQ_DET_IRQ_EN
        total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else pass_cnt++;
`endif
    endtask

    task automatic test_default_overlap();
        pulse_start();
        total_cnt++; if (busy !== 1'b1) $display("FAIL ovl_busy_start: got %b want 1", busy); else pass_cnt++;
        send_stream(16'b1001001, 16'b0001001, 7);
        total_cnt++; if (match_count !== 8'd2) $display("FAIL ovl_count: got %0d want 2", match_count); else pass_cnt++;
        pulse_start();
        total_cnt++; if (match_count !== 8'd2) $display("FAIL start_in_run_count: got %0d want 2", match_count); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL start_in_run_busy: got %b want 1", busy); else pass_cnt++;
    endtask

    task automatic test_non_overlap();
        pulse_abort();
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (match_count !== 8'd2) $display("FAIL abort_count_kept: got %0d want 2", match_count); else pass_cnt++;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_pattern = 4'b1001;
        cfg_if.cfg_overlap = 1'b0;
        cfg_if.cfg_limit = 8'd0;
        tick();
        cfg_if.cfg_valid = 1'b0;
        pulse_start();
        total_cnt++; if (match_count !== 8'd0) $display("FAIL start_clears_count: got %0d want 0", match_count); else pass_cnt++;
        send_stream(16'b1001001, 16'b0001000, 7);
        total_cnt++; if (match_count !== 8'd1) $display("FAIL novl_count: got %0d want 1", match_count); else pass_cnt++;
    endtask

    task automatic test_limit();
        pulse_abort();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_pattern = 4'b1001;
        cfg_if.cfg_overlap = 1'b1;
        cfg_if.cfg_limit = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL limit_busy: got %b want 1", busy); else pass_cnt++;
        send_stream(16'b1001001, 16'b0001001, 7);
        total_cnt++; if (done !== 1'b1) $display("FAIL limit_done: got %b want 1", done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL limit_busy_off: got %b want 0", busy); else pass_cnt++;
`ifdef SEQ_DET_IRQ_EN
        total_cnt++; if (irq !== 1'b1) $display("FAIL limit_irq: got %b want 1", irq); else pass_cnt++;
`endif
        pulse_abort();
        total_cnt++; if (done !== 1'b1) $display("FAIL abort_in_done: got %b want 1", done); else pass_cnt++;
        send_stream(16'b1001, 16'b0000, 4);
        total_cnt++; if (match_count !== 8'd2) $display("FAIL done_count_hold: got %0d want 2", match_count); else pass_cnt++;
        total_cnt++; if (done !== 1'b1) $display("FAIL done_hold: got %b want 1", done); else pass_cnt++;
    endtask

    task automatic test_cfg_during_run();
        pulse_start();
        total_cnt++; if (match_count !== 8'd0) $display("FAIL rerun_count: got %0d want 0", match_count); else pass_cnt++;
`ifdef SEQ_DET_IRQ_EN
        total_cnt++; if (irq !== 1'b0) $display("FAIL irq_clear_on_start: got %b want 0", irq); else pass_cnt++;
`endif
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_pattern = 4'b1111;
        cfg_if.cfg_overlap = 1'b1;
        cfg_if.cfg_limit = 8'd0;
        tick();
        total_cnt++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL run_cfg_ready: got %b want 0", cfg_if.cfg_ready); else pass_cnt++;
        send_stream(16'b1001, 16'b0001, 4);
        total_cnt++; if (match_count !== 8'd1) $display("FAIL run_cfg_old_pattern: got %0d want 1", match_count); else pass_cnt++;
        pulse_abort();
        total_cnt++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL idle_cfg_ready: got %b want 1", cfg_if.cfg_ready); else pass_cnt++;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic test_gaps();
        pulse_start();
        send_bit(1'b1, 1'b0);
        tick();
        send_bit(1'b1, 1'b0);
        tick();
        tick();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        tick();
        send_bit(1'b1, 1'b1);
        total_cnt++; if (match_count !== 8'd2) $display("FAIL gaps_count: got %0d want 2", match_count); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        pulse_abort();
        pulse_start();
        send_stream(16'b100, 16'b000, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (match_count !== 8'd0) $display("FAIL midrst_count: got %0d want 0", match_count); else pass_cnt++;
        pulse_start();
        send_stream(16'b1001, 16'b0001, 4);
        total_cnt++; if (match_count !== 8'd1) $display("FAIL midrst_pattern: got %0d want 1", match_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_default_overlap();
        test_non_overlap();
        test_limit();
        test_cfg_during_run();
        test_gaps();
        test_reset_mid_run();
        tick();
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
